// File: rtl/dcache_snoop_responder.sv
// rtl/dcache_snoop_responder.sv - MSI snoop responder for one data cache
//
// Answers coherence snoops from the bus controller. A snoop is latched when
// ccwait is seen in IDLE, the indexed set is looked up once, a dirty block is
// supplied word by word, and the MSI transition (M->S or invalidate) is
// written back through a one-cycle update strobe.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ccwait, ccinv        snoop request and its invalidate qualifier
//   ccsnoopaddr          snooped byte address
//   dwait                controller stall for the supplied word
//   cctrans              responder is mid-transition
//   ccwrite              block was dirty and is being supplied
//   snoop_daddr/_dstore  supplied word address and data
//   snoop_active         cache FSM must keep off the array
//   arr_idx              set index for the combinational array read
//   arr_tag/_valid/_dirty/_data  contents of the indexed set
//   upd_en/_way/_valid/_dirty    state write-back strobe and new state
module dcache_snoop_responder #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int IDXW = $clog2(SETS),
    localparam int TAGW = 29 - IDXW,
    localparam int WAYW = $clog2(WAYS)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ccwait,
    input  logic                   ccinv,
    input  logic [31:0]            ccsnoopaddr,
    input  logic                   dwait,
    output logic                   cctrans,
    output logic                   ccwrite,
    output logic [31:0]            snoop_daddr,
    output logic [31:0]            snoop_dstore,
    output logic                   snoop_active,
    output logic [IDXW-1:0]        arr_idx,
    input  logic [WAYS*TAGW-1:0]   arr_tag,
    input  logic [WAYS-1:0]        arr_valid,
    input  logic [WAYS-1:0]        arr_dirty,
    input  logic [WAYS*64-1:0]     arr_data,
    output logic                   upd_en,
    output logic [WAYW-1:0]        upd_way,
    output logic                   upd_valid,
    output logic                   upd_dirty
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        SUPPLY0 = 3'd2,
        SUPPLY1 = 3'd3,
        UPDATE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              inv_q, inv_d;
    logic [WAYW-1:0]   way_q, way_d;
    logic              dirty_q, dirty_d;
    logic [63:0]       data_q, data_d;

    logic              cctrans_q, cctrans_d;
    logic              ccwrite_q, ccwrite_d;
    logic [31:0]       snoop_daddr_q, snoop_daddr_d;
    logic [31:0]       snoop_dstore_q, snoop_dstore_d;
    logic              snoop_active_q, snoop_active_d;
    logic              upd_en_q, upd_en_d;
    logic [WAYW-1:0]   upd_way_q, upd_way_d;
    logic              upd_valid_q, upd_valid_d;

    logic              hit;
    logic [WAYW-1:0]   hit_way;
    logic              hit_dirty;
    logic [63:0]       hit_data;

    // Word and byte offset bits never matter: the whole block is supplied.
    logic unused_offset_bits;
    assign unused_offset_bits = ^ccsnoopaddr[2:0];

    // Scan from the top way down so the lowest matching way is the one kept.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        hit_dirty = 1'b0;
        hit_data  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (arr_valid[w] && arr_tag[w*TAGW +: TAGW] == tag_q) begin
                hit       = 1'b1;
                hit_way   = WAYW'(w);
                hit_dirty = arr_dirty[w];
                hit_data  = arr_data[w*64 +: 64];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        inv_d   = inv_q;
        way_d   = way_q;
        dirty_d = dirty_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (ccwait) begin
                    tag_d   = ccsnoopaddr[31:IDXW+3];
                    idx_d   = ccsnoopaddr[IDXW+2:3];
                    inv_d   = ccinv;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // Block data is captured here so the supplied words stay
                // stable however long the controller stalls.
                way_d   = hit_way;
                dirty_d = hit && hit_dirty;
                data_d  = hit_data;
                if (hit && hit_dirty)  state_d = SUPPLY0;
                else if (hit && inv_q) state_d = UPDATE;
                else                   state_d = DONE;
            end
            SUPPLY0: if (!dwait) state_d = SUPPLY1;
            SUPPLY1: if (!dwait) state_d = UPDATE;
            UPDATE:  state_d = DONE;
            DONE:    if (!ccwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so none
        // of them has a combinational path from an input.
        snoop_active_d = (state_d != IDLE);
        cctrans_d      = (state_d == LOOKUP) || (state_d == SUPPLY0) ||
                         (state_d == SUPPLY1) || (state_d == UPDATE);
        ccwrite_d      = dirty_d && ((state_d == SUPPLY0) || (state_d == SUPPLY1) ||
                                     (state_d == UPDATE) || (state_d == DONE));
        upd_en_d       = (state_d == UPDATE);
        upd_way_d      = (state_d == UPDATE) ? way_d : '0;
        upd_valid_d    = (state_d == UPDATE) && !inv_d;
        snoop_daddr_d  = '0;
        snoop_dstore_d = '0;
        if (state_d == SUPPLY0) begin
            snoop_daddr_d  = {tag_d, idx_d, 3'b000};
            snoop_dstore_d = data_d[31:0];
        end else if (state_d == SUPPLY1) begin
            snoop_daddr_d  = {tag_d, idx_d, 3'b100};
            snoop_dstore_d = data_d[63:32];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            tag_q          <= '0;
            idx_q          <= '0;
            inv_q          <= 1'b0;
            way_q          <= '0;
            dirty_q        <= 1'b0;
            data_q         <= '0;
            cctrans_q      <= 1'b0;
            ccwrite_q      <= 1'b0;
            snoop_daddr_q  <= '0;
            snoop_dstore_q <= '0;
            snoop_active_q <= 1'b0;
            upd_en_q       <= 1'b0;
            upd_way_q      <= '0;
            upd_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            idx_q          <= idx_d;
            inv_q          <= inv_d;
            way_q          <= way_d;
            dirty_q        <= dirty_d;
            data_q         <= data_d;
            cctrans_q      <= cctrans_d;
            ccwrite_q      <= ccwrite_d;
            snoop_daddr_q  <= snoop_daddr_d;
            snoop_dstore_q <= snoop_dstore_d;
            snoop_active_q <= snoop_active_d;
            upd_en_q       <= upd_en_d;
            upd_way_q      <= upd_way_d;
            upd_valid_q    <= upd_valid_d;
        end
    end

    assign cctrans      = cctrans_q;
    assign ccwrite      = ccwrite_q;
    assign snoop_daddr  = snoop_daddr_q;
    assign snoop_dstore = snoop_dstore_q;
    assign snoop_active = snoop_active_q;
    assign arr_idx      = idx_q;
    assign upd_en       = upd_en_q;
    assign upd_way      = upd_way_q;
    assign upd_valid    = upd_valid_q;
    // A snoop never leaves a block dirty.
    assign upd_dirty    = 1'b0;

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb/tb_dcache_snoop_responder.sv - self-checking bench for dcache_snoop_responder
module tb_dcache_snoop_responder;

    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int IDXW = 3;
    localparam int TAGW = 26;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ccwait, ccinv, dwait;
    logic [31:0]       ccsnoopaddr;
    logic              cctrans, ccwrite, snoop_active;
    logic [31:0]       snoop_daddr, snoop_dstore;
    logic [IDXW-1:0]   arr_idx;
    logic [WAYS*TAGW-1:0] arr_tag;
    logic [WAYS-1:0]   arr_valid, arr_dirty;
    logic [WAYS*64-1:0] arr_data;
    logic              upd_en, upd_valid, upd_dirty;
    logic [0:0]        upd_way;

    // Behavioural cache array: the model of what the cache holds.
    logic [TAGW-1:0] m_tag   [SETS][WAYS];
    logic            m_valid [SETS][WAYS];
    logic            m_dirty [SETS][WAYS];
    logic [63:0]     m_data  [SETS][WAYS];

    assign arr_tag   = {m_tag[arr_idx][1], m_tag[arr_idx][0]};
    assign arr_valid = {m_valid[arr_idx][1], m_valid[arr_idx][0]};
    assign arr_dirty = {m_dirty[arr_idx][1], m_dirty[arr_idx][0]};
    assign arr_data  = {m_data[arr_idx][1], m_data[arr_idx][0]};

    dcache_snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .cctrans(cctrans),
        .ccwrite(ccwrite), .snoop_daddr(snoop_daddr), .snoop_dstore(snoop_dstore),
        .snoop_active(snoop_active), .arr_idx(arr_idx), .arr_tag(arr_tag),
        .arr_valid(arr_valid), .arr_dirty(arr_dirty), .arr_data(arr_data),
        .upd_en(upd_en), .upd_way(upd_way), .upd_valid(upd_valid), .upd_dirty(upd_dirty)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_pulses = 0;

    always @(negedge CLK) if (upd_en) upd_pulses++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observations of one snoop transaction.
    int          o_cct, o_nwords, o_nupd, o_done;
    logic        o_write_seen, o_unstable, o_leak, o_first_cct, o_timeout, o_done_write;
    logic [31:0] o_waddr [2];
    logic [31:0] o_wdata [2];
    logic        o_uway, o_uvalid, o_udirty;

    task automatic run_snoop(input logic [31:0] addr, input logic inv, input int w, input logic drop);
        int hold;
        bit ended;
        bit supplying;
        logic [31:0] ha, hd;
        o_cct = 0; o_nwords = 0; o_nupd = 0; o_done = 0;
        o_write_seen = 0; o_unstable = 0; o_leak = 0; o_first_cct = 0; o_done_write = 0;
        o_waddr[0] = 0; o_waddr[1] = 0; o_wdata[0] = 0; o_wdata[1] = 0;
        o_uway = 0; o_uvalid = 0; o_udirty = 0;
        hold = 0; ended = 0; ha = 0; hd = 0;
        @(negedge CLK);
        ccwait = 1; ccinv = inv; ccsnoopaddr = addr; dwait = 1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge CLK);
            if (cyc == 0) o_first_cct = cctrans;
            if (!snoop_active) begin ended = 1; break; end
            // Junk on the address bus checks that the snoop was latched.
            ccinv = 0;
            ccsnoopaddr = $urandom;
            if (cctrans) o_cct++;
            if (ccwrite) o_write_seen = 1;
            supplying = cctrans && ccwrite && !upd_en;
            if (!supplying && (snoop_daddr != 0 || snoop_dstore != 0)) o_leak = 1;
            if (supplying) begin
                if (hold == 0) begin
                    ha = snoop_daddr; hd = snoop_dstore;
                    if (drop) ccwait = 0;
                end else if (snoop_daddr !== ha || snoop_dstore !== hd) begin
                    o_unstable = 1;
                end
                hold++;
                if (hold <= w) dwait = 1;
                else begin
                    dwait = 0;
                    if (o_nwords < 2) begin o_waddr[o_nwords] = ha; o_wdata[o_nwords] = hd; end
                    o_nwords++;
                    hold = 0;
                end
            end else begin
                dwait = 1;
            end
            if (upd_en) begin
                o_nupd++; o_uway = upd_way; o_uvalid = upd_valid; o_udirty = upd_dirty;
            end
            if (!cctrans && snoop_active) begin
                o_done++;
                o_done_write = ccwrite;
                if (o_done == 3 && ccwait) ccwait = 0;
            end
        end
        o_timeout = !ended;
        ccwait = 0; dwait = 0; ccsnoopaddr = 0;
    endtask

    task automatic check_run(input string nm, input int e_cct, input logic e_write,
                             input logic [31:0] e_a0, input logic [31:0] e_w0, input logic [31:0] e_w1,
                             input int e_nupd, input logic e_way, input logic e_valid, input logic drop);
        chk({nm, " timeout"}, o_timeout, 0);
        chk({nm, " cctrans_first"}, o_first_cct, 1);
        chk({nm, " cctrans_cycles"}, o_cct, e_cct);
        chk({nm, " ccwrite"}, o_write_seen, e_write);
        chk({nm, " ccwrite_done"}, o_done_write, e_write);
        chk({nm, " nwords"}, o_nwords, e_write ? 2 : 0);
        if (e_write) begin
            chk({nm, " addr0"}, o_waddr[0], e_a0);
            chk({nm, " data0"}, o_wdata[0], e_w0);
            chk({nm, " addr1"}, o_waddr[1], e_a0 | 32'h4);
            chk({nm, " data1"}, o_wdata[1], e_w1);
        end
        chk({nm, " stable"}, o_unstable, 0);
        chk({nm, " zero_outside"}, o_leak, 0);
        chk({nm, " nupd"}, o_nupd, e_nupd);
        if (e_nupd > 0) begin
            chk({nm, " upd_way"}, o_uway, e_way);
            chk({nm, " upd_valid"}, o_uvalid, e_valid);
            chk({nm, " upd_dirty"}, o_udirty, 0);
        end
        chk({nm, " done_cycles"}, o_done, (drop && e_write) ? 1 : 3);
    endtask

    typedef struct {
        logic [TAGW-1:0] t0; logic v0; logic d0;
        logic [TAGW-1:0] t1; logic v1; logic d1;
        logic [31:0] addr; logic inv; int w; logic drop;
        int e_cct; logic e_write; logic [31:0] e_w0; logic [31:0] e_w1;
        int e_nupd; logic e_way; logic e_valid;
    } vec_t;

    task automatic clear_array();
        for (int s = 0; s < SETS; s++)
            for (int k = 0; k < WAYS; k++) begin
                m_tag[s][k] = 0; m_valid[s][k] = 0; m_dirty[s][k] = 0; m_data[s][k] = 0;
            end
    endtask

    task automatic load_set1(input vec_t v);
        clear_array();
        m_tag[1][0] = v.t0; m_valid[1][0] = v.v0; m_dirty[1][0] = v.d0;
        m_tag[1][1] = v.t1; m_valid[1][1] = v.v1; m_dirty[1][1] = v.d1;
        m_data[1][0] = 64'h3333_4444_1111_2222;
        m_data[1][1] = 64'hBEEF_0001_CAFE_0000;
    endtask

    // Reference: MSI snoop rules applied directly to the model array.
    task automatic predict(input logic [31:0] addr, input logic inv, input int w,
                           output int e_cct, output logic e_write, output logic [31:0] e_a0,
                           output logic [31:0] e_w0, output logic [31:0] e_w1,
                           output int e_nupd, output logic e_way, output logic e_valid);
        int s;
        bit hit;
        s = int'(addr[5:3]);
        hit = 0; e_way = 0;
        for (int k = 0; k < WAYS; k++)
            if (!hit && m_valid[s][k] && m_tag[s][k] == addr[31:6]) begin hit = 1; e_way = k[0]; end
        e_write = hit && m_dirty[s][e_way];
        e_a0    = {addr[31:3], 3'b000};
        e_w0    = m_data[s][e_way][31:0];
        e_w1    = m_data[s][e_way][63:32];
        e_cct   = !hit ? 1 : e_write ? 4 + 2 * w : inv ? 2 : 1;
        e_nupd  = (hit && (e_write || inv)) ? 1 : 0;
        e_valid = !inv;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0,0,0, 1,1,1, 32'h48, 0, 0, 0, 4, 1, 32'hCAFE0000, 32'hBEEF0001, 1, 1, 1};
        vecs[1] = '{0,0,0, 1,1,1, 32'h48, 1, 3, 0, 10, 1, 32'hCAFE0000, 32'hBEEF0001, 1, 1, 0};
        vecs[2] = '{1,1,0, 5,0,0, 32'h48, 1, 0, 0, 2, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{2,1,1, 3,1,1, 32'h48, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{0,0,0, 1,1,1, 32'h48, 0, 1, 1, 6, 1, 32'hCAFE0000, 32'hBEEF0001, 1, 1, 1};
        vecs[5] = '{1,1,0, 1,1,1, 32'h48, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{0,0,0, 1,1,1, 32'h4F, 0, 2, 0, 8, 1, 32'hCAFE0000, 32'hBEEF0001, 1, 1, 1};

        clear_array();
        nRST = 0; ccwait = 0; ccinv = 0; dwait = 0; ccsnoopaddr = 0;
        @(negedge CLK);
        chk("reset ctrl", {cctrans, ccwrite, snoop_active, upd_en, upd_valid, upd_dirty, upd_way}, 0);
        chk("reset daddr", snoop_daddr, 0);
        chk("reset dstore", snoop_dstore, 0);
        chk("reset idx", arr_idx, 0);
        @(negedge CLK);
        nRST = 1;

        for (int i = 0; i < 7; i++) begin
            load_set1(vecs[i]);
            run_snoop(vecs[i].addr, vecs[i].inv, vecs[i].w, vecs[i].drop);
            check_run($sformatf("vec%0d", i), vecs[i].e_cct, vecs[i].e_write, 32'h48,
                      vecs[i].e_w0, vecs[i].e_w1, vecs[i].e_nupd, vecs[i].e_way,
                      vecs[i].e_valid, vecs[i].drop);
        end

        // ccinv without ccwait must be ignored.
        begin
            int p0;
            p0 = upd_pulses;
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                ccinv = 1; ccwait = 0; ccsnoopaddr = 32'h48;
                @(negedge CLK);
                chk("inv_idle active", snoop_active, 0);
                chk("inv_idle cctrans", cctrans, 0);
            end
            ccinv = 0;
            chk("inv_idle upd", upd_pulses, p0);
        end

        // Asynchronous reset while stalled in the second supply word.
        begin
            int p0;
            bit found;
            load_set1(vecs[0]);
            found = 0;
            @(negedge CLK);
            ccwait = 1; ccsnoopaddr = 32'h48; dwait = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge CLK);
                if (snoop_daddr == 32'h4C) begin found = 1; dwait = 1; end
            end
            chk("rst_mid reached_supply1", found, 1);
            @(negedge CLK);
            @(negedge CLK);
            p0 = upd_pulses;
            #2 nRST = 0;
            #1;
            chk("rst_mid ctrl", {cctrans, ccwrite, snoop_active, upd_en, upd_valid, upd_dirty, upd_way}, 0);
            chk("rst_mid daddr", snoop_daddr, 0);
            chk("rst_mid dstore", snoop_dstore, 0);
            ccwait = 0; dwait = 0;
            @(negedge CLK);
            nRST = 1;
            @(negedge CLK);
            @(negedge CLK);
            chk("rst_mid idle", snoop_active, 0);
            chk("rst_mid no_upd", upd_pulses, p0);
        end

        // Random array contents and snoops against the model.
        for (int s = 0; s < SETS; s++)
            for (int k = 0; k < WAYS; k++) begin
                m_tag[s][k]   = TAGW'($urandom_range(0, 3));
                m_valid[s][k] = $urandom_range(0, 1);
                m_dirty[s][k] = $urandom_range(0, 1);
                m_data[s][k]  = {$urandom, $urandom};
            end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic inv, drop, e_write, e_way, e_valid;
            logic [31:0] e_a0, e_w0, e_w1;
            int w, e_cct, e_nupd;
            a    = {TAGW'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            inv  = $urandom_range(0, 1);
            drop = $urandom_range(0, 1);
            w    = $urandom_range(0, 2);
            predict(a, inv, w, e_cct, e_write, e_a0, e_w0, e_w1, e_nupd, e_way, e_valid);
            run_snoop(a, inv, w, drop);
            check_run($sformatf("rnd%0d", i), e_cct, e_write, e_a0, e_w0, e_w1,
                      e_nupd, e_way, e_valid, drop);
            if (e_nupd > 0) begin
                m_valid[int'(a[5:3])][e_way] = e_valid;
                m_dirty[int'(a[5:3])][e_way] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
